// File: rtl/count_checker.sv
// count_checker: receive-side monitor for a free-running +1 count stream.
// Acquires lock after LOCK_COUNT consecutive in-sequence words. While locked,
// it flags each out-of-sequence word and keeps a saturating error tally. The
// expected value keeps advancing through bad words (flywheel) and is never
// resynchronised to them. Lock is dropped after ERR_LIMIT consecutive bad words.
module count_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_err,
  output logic             locked,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [15:0]      err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] ERR_C  = BW'(ERR_LIMIT);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t        state;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;

  logic             match;
  logic [GW-1:0]    good_nxt;
  logic [BW-1:0]    bad_nxt;
  logic [WIDTH-1:0] data_inc;
  logic [WIDTH-1:0] exp_inc;

  // Saturating increment of the error tally; never wraps past all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Case equality so that an unknown word never counts as a match.
  always_comb begin
    match    = (in_data === expected);
    good_nxt = good_cnt + GW'(1);
    bad_nxt  = bad_cnt + BW'(1);
    data_inc = in_data + WIDTH'(1);
    exp_inc  = expected + WIDTH'(1);
  end

  // Lock FSM, expected-word tracking, error tally; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      expected  <= '0;
      err_count <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            expected <= data_inc;
            good_cnt <= GW'(1);
            state    <= SYNC;
          end
          SYNC: begin
            expected <= data_inc;
            if (match) begin
              good_cnt <= good_nxt;
              if (good_nxt == LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= GW'(1);
            end
          end
          LOCKED: begin
            expected <= exp_inc;
            if (match) begin
              bad_cnt <= '0;
            end else begin
              mismatch  <= 1'b1;
              err_count <= sat_inc16(err_count);
              if (bad_nxt == ERR_C) begin
                state    <= HUNT;
                locked   <= 1'b0;
                bad_cnt  <= '0;
                good_cnt <= '0;
              end else begin
                bad_cnt <= bad_nxt;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
      // A clear issued alongside a counted mismatch still leaves the tally at zero.
      if (clear_err) err_count <= '0;
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: a vector table of stimulus plus hand-computed
// outputs, run through a scoreboard queue, followed by a gapped-valid sequence.
module tb_count_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear_err;
  logic        locked;
  logic        mismatch;
  logic [7:0]  expected;
  logic [15:0] err_count;

  count_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked), .mismatch(mismatch),
    .expected(expected), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, v;
    logic [7:0]  d;
    logic        c;
    logic        l, m;
    logic [7:0]  e;
    logic [15:0] n;
  } vec_t;

  typedef struct {
    int          tag;
    logic        l, m;
    logic [7:0]  e;
    logic [15:0] n;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(logic r, logic v, logic [7:0] d, logic c,
                              logic l, logic m, logic [7:0] e, logic [15:0] n);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.c = c;
    x.l = l; x.m = m; x.e = e; x.n = n;
    vecs.push_back(x);
  endfunction

  task automatic check();
    exp_t x;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: output seen with no expectation queued");
      return;
    end
    x = sb.pop_front();
    n_vec++;
    if ({locked, mismatch, expected, err_count} !== {x.l, x.m, x.e, x.n}) begin
      n_bad++;
      $display("FAIL vec%0d: got locked=%0b mismatch=%0b expected=%0d err_count=%0d, want locked=%0b mismatch=%0b expected=%0d err_count=%0d",
               x.tag, locked, mismatch, expected, err_count, x.l, x.m, x.e, x.n);
    end
  endtask

  task automatic apply(int tag, logic r, logic v, logic [7:0] d, logic c,
                       logic l, logic m, logic [7:0] e, logic [15:0] n);
    exp_t x;
    reset = r; in_valid = v; in_data = d; clear_err = c;
    x.tag = tag; x.l = l; x.m = m; x.e = e; x.n = n;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words[6];
    int         gaps[6];
    logic [7:0] cur_e;
    logic       cur_l;
    int         tag;

    // reset, acquire on 5,6,7,8
    add(1,0,  0,0, 0,0,  0,0);
    add(0,1,  5,0, 0,0,  6,0);
    add(0,1,  6,0, 0,0,  7,0);
    add(0,1,  7,0, 0,0,  8,0);
    add(0,1,  8,0, 1,0,  9,0);
    // single bad word: flywheel, lock held
    add(0,1,  9,0, 1,0, 10,0);
    add(0,1, 99,0, 1,1, 11,1);
    add(0,1, 11,0, 1,0, 12,1);
    add(0,1, 12,0, 1,0, 13,1);
    add(0,0, 77,0, 1,0, 13,1);
    // three bad words in a row drop lock, then relock
    add(0,1, 50,0, 1,1, 14,2);
    add(0,1, 50,0, 1,1, 15,3);
    add(0,1, 50,0, 0,1, 16,4);
    add(0,1, 30,0, 0,0, 31,4);
    add(0,1, 31,0, 0,0, 32,4);
    add(0,1, 32,0, 0,0, 33,4);
    add(0,1, 33,0, 1,0, 34,4);
    // a good word between bad ones restarts the consecutive count
    add(0,1,  0,0, 1,1, 35,5);
    add(0,1, 35,0, 1,0, 36,5);
    add(0,1,  0,0, 1,1, 37,6);
    add(0,1,  0,0, 1,1, 38,7);
    add(0,1, 38,0, 1,0, 39,7);
    // clear coincident with mismatch, clear with a good word, idle clear
    add(0,1,  0,1, 1,1, 40,0);
    add(0,1,  0,0, 1,1, 41,1);
    add(0,1, 41,1, 1,0, 42,0);
    add(0,0,  0,1, 1,0, 42,0);
    // build up errors then reset mid-LOCKED with a bad word present
    add(0,1,  0,0, 1,1, 43,1);
    add(0,1, 43,0, 1,0, 44,1);
    add(0,1,  0,0, 1,1, 45,2);
    add(0,1, 45,0, 1,0, 46,2);
    add(0,1,  0,0, 1,1, 47,3);
    add(1,1,  0,0, 0,0,  0,0);
    add(0,0,  5,0, 0,0,  0,0);
    // lock then cross the wrap while locked
    add(0,1,250,0, 0,0,251,0);
    add(0,1,251,0, 0,0,252,0);
    add(0,1,252,0, 0,0,253,0);
    add(0,1,253,0, 1,0,254,0);
    add(0,1,254,0, 1,0,255,0);
    add(0,1,255,0, 1,0,  0,0);
    add(0,1,  0,0, 1,0,  1,0);
    add(0,1,  1,0, 1,0,  2,0);
    // acquire across the wrap
    add(1,0,  0,0, 0,0,  0,0);
    add(0,1,254,0, 0,0,255,0);
    add(0,1,255,0, 0,0,  0,0);
    add(0,1,  0,0, 0,0,  1,0);
    add(0,1,  1,0, 1,0,  2,0);
    // resync in SYNC: 3,4 then 9,10,11,12
    add(1,0,  0,0, 0,0,  0,0);
    add(0,1,  3,0, 0,0,  4,0);
    add(0,1,  4,0, 0,0,  5,0);
    add(0,1,  9,0, 0,0, 10,0);
    add(0,1, 10,0, 0,0, 11,0);
    add(0,1, 11,0, 0,0, 12,0);
    add(0,1, 12,0, 1,0, 13,0);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_err = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      apply(i, vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].c,
            vecs[i].l, vecs[i].m, vecs[i].e, vecs[i].n);

    // Same resync scenario with 1-3 idle cycles between words.
    words = '{8'd3, 8'd4, 8'd9, 8'd10, 8'd11, 8'd12};
    gaps  = '{1, 2, 3, 1, 2, 3};
    tag   = 1000;
    apply(tag++, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    cur_e = 8'd0;
    cur_l = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cur_e = words[i] + 8'd1;
      cur_l = (i == 5);
      apply(tag++, 1'b0, 1'b1, words[i], 1'b0, cur_l, 1'b0, cur_e, 16'd0);
      for (int g = 0; g < gaps[i]; g++)
        apply(tag++, 1'b0, 1'b0, 8'hA5, 1'b0, cur_l, 1'b0, cur_e, 16'd0);
    end

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
